// File: rtl/sound_pkg.sv
// Shared constants and helpers for the sound mixer slice: DAC mode codes,
// pipeline sum width and mix saturation.
package sound_pkg;

  localparam int MODE_PWM = 0;
  localparam int MODE_SDM = 1;

  // Width that holds CH full-scale channels plus the beeper and tape levels.
  function automatic int SW(input int dw, input int ch);
    return dw + $clog2(ch + 2);
  endfunction

  function automatic logic [31:0] sat(input logic [31:0] value, input int dw);
    logic [31:0] max_val;
    max_val = (32'd1 << dw) - 32'd1;
    return (value > max_val) ? max_val : value;
  endfunction

endpackage

// File: rtl/sound_dac.sv
// 1-bit audio DAC: PWM with per-period duty latch, or first-order sigma-delta.
// A free-running counter marks the 2^DW-cycle sample period in both modes.
module sound_dac
  import sound_pkg::*;
#(
  parameter int DW   = 8,
  parameter int MODE = MODE_PWM
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] mix,
  output logic          dac_out,
  output logic          sample_stb
);

  logic [DW-1:0] cnt_reg;
  logic          dac_reg;
  logic          dac_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + DW'(1);
    end
  end

  // Gated with rst_n so the strobe stays low while reset is held, yet the
  // first cycle after release (cnt still 0) is already a period start.
  assign sample_stb = rst_n && (cnt_reg == '0);

  generate
    if (MODE == MODE_SDM) begin : g_sdm
      logic [DW:0] acc_reg;
      logic [DW:0] acc_next;

      always_comb begin
        acc_next = {1'b0, acc_reg[DW-1:0]} + {1'b0, mix};
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          acc_reg <= '0;
        end else begin
          acc_reg <= acc_next;
        end
      end

      assign dac_next = acc_next[DW];
    end else begin : g_pwm
      logic [DW-1:0] duty_reg;
      logic [DW-1:0] duty_eff;

      // The period-start cycle already compares against the incoming mix so
      // the high run is contiguous from the start of the period.
      always_comb begin
        duty_eff = (cnt_reg == '0) ? mix : duty_reg;
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          duty_reg <= '0;
        end else if (cnt_reg == '0) begin
          duty_reg <= mix;
        end
      end

      assign dac_next = (cnt_reg < duty_eff);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dac_reg <= 1'b0;
    end else begin
      dac_reg <= dac_next;
    end
  end

  assign dac_out = dac_reg;

endmodule

// File: rtl/sound_mixer.sv
// Beeper, tape-out and CH covox channels summed, scaled and saturated into a
// DW-bit mix, then turned into a 1-bit audio stream by sound_dac.
module sound_mixer
  import sound_pkg::*;
#(
  parameter int            CH       = 4,
  parameter int            DW       = 8,
  parameter int            SHIFT    = 2,
  parameter int            MODE     = MODE_PWM,
  parameter logic [DW-1:0] BEEP_LVL = 8'h80,
  parameter logic [DW-1:0] TAPE_LVL = 8'h20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  input  logic [CH-1:0] covox_wr,
  input  logic          beeper_wr,
  output logic [DW-1:0] mix,
  output logic          dac_out,
  output logic          sample_stb
);

  localparam int SUM_W = SW(DW, CH);

  logic [CH*DW-1:0] chan_flat;
  logic             beep_reg;
  logic             tape_reg;
  logic [SUM_W-1:0] sum_reg;
  logic [SUM_W-1:0] sum_next;
  logic [SUM_W-1:0] shifted;
  logic [DW-1:0]    mix_reg;
  logic [DW-1:0]    mix_next;

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_chan
      logic [DW-1:0] chan_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          chan_reg <= '0;
        end else if (covox_wr[gi]) begin
          chan_reg <= din;
        end
      end

      assign chan_flat[gi*DW +: DW] = chan_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beep_reg <= 1'b0;
      tape_reg <= 1'b0;
    end else if (beeper_wr) begin
      beep_reg <= din[4];
      tape_reg <= din[3];
    end
  end

  always_comb begin
    sum_next = '0;
    for (int k = 0; k < CH; k++) begin
      sum_next = sum_next + SUM_W'(chan_flat[k*DW +: DW]);
    end
    if (beep_reg) sum_next = sum_next + SUM_W'(BEEP_LVL);
    if (tape_reg) sum_next = sum_next + SUM_W'(TAPE_LVL);
  end

  always_comb begin
    shifted  = sum_reg >> SHIFT;
    mix_next = DW'(sat(32'(shifted), DW));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_reg <= '0;
      mix_reg <= '0;
    end else begin
      sum_reg <= sum_next;
      mix_reg <= mix_next;
    end
  end

  assign mix = mix_reg;

  sound_dac #(
    .DW   (DW),
    .MODE (MODE)
  ) u_dac (
    .clk        (clk),
    .rst_n      (rst_n),
    .mix        (mix_reg),
    .dac_out    (dac_out),
    .sample_stb (sample_stb)
  );

endmodule

// File: tb/tb_sound_mixer.sv
// Directed + randomized bench for sound_mixer: one PWM and one sigma-delta
// instance share the write bus and are checked against an arithmetic model.
module tb_sound_mixer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic [3:0] covox_wr;
  logic       beeper_wr;
  logic [7:0] mix_pwm, mix_sdm;
  logic       dac_pwm, dac_sdm, stb_pwm, stb_sdm;

  int checks = 0;
  int errors = 0;

  int m_chan [4];
  int m_beep;
  int m_tape;

  always #5 clk = ~clk;

  sound_mixer #(.CH(4), .DW(8), .SHIFT(2), .MODE(0),
                .BEEP_LVL(8'h80), .TAPE_LVL(8'h20)) dut_pwm (
    .clk(clk), .rst_n(rst_n), .din(din), .covox_wr(covox_wr),
    .beeper_wr(beeper_wr), .mix(mix_pwm), .dac_out(dac_pwm),
    .sample_stb(stb_pwm)
  );

  sound_mixer #(.CH(4), .DW(8), .SHIFT(2), .MODE(1),
                .BEEP_LVL(8'h80), .TAPE_LVL(8'h20)) dut_sdm (
    .clk(clk), .rst_n(rst_n), .din(din), .covox_wr(covox_wr),
    .beeper_wr(beeper_wr), .mix(mix_sdm), .dac_out(dac_sdm),
    .sample_stb(stb_sdm)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Mix the spec's arithmetic predicts from the programmed register values.
  function automatic int exp_mix();
    int s;
    s = 0;
    for (int k = 0; k < 4; k++) s += m_chan[k];
    s += m_beep * 128 + m_tape * 32;
    s = s / 4;
    return (s > 255) ? 255 : s;
  endfunction

  task automatic model_write(input logic [3:0] mask, input logic bw, input logic [7:0] data);
    for (int k = 0; k < 4; k++) if (mask[k]) m_chan[k] = int'(data);
    if (bw) begin
      m_beep = int'(data[4]);
      m_tape = int'(data[3]);
    end
  endtask

  // One bus write, then checks mix is unchanged one edge later and correct two.
  task automatic xact(input logic [3:0] mask, input logic bw, input logic [7:0] data);
    int old_mix;
    old_mix   = exp_mix();
    covox_wr  = mask;
    beeper_wr = bw;
    din       = data;
    tick();
    covox_wr  = 4'b0000;
    beeper_wr = 1'b0;
    model_write(mask, bw, data);
    tick();
    check("mix_hold_pwm", 32'(mix_pwm), 32'(old_mix));
    tick();
    check("mix_pwm", 32'(mix_pwm), 32'(exp_mix()));
    check("mix_sdm", 32'(mix_sdm), 32'(exp_mix()));
    $display("xact mask=%b bw=%0d din=%02h mix=%02h expect=%02h",
             mask, bw, data, mix_pwm, exp_mix());
  endtask

  task automatic wait_stb();
    int n;
    n = 0;
    while (stb_pwm !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check("stb_wait", 32'(stb_pwm), 32'd1);
  endtask

  // Called at a period-start cycle; walks the whole period checking each DAC bit.
  task automatic pwm_period(input int duty, input int chg_at, input logic [7:0] chg_data);
    for (int p = 1; p < 256; p++) begin
      if (p == chg_at) begin
        covox_wr = 4'b1111;
        din      = chg_data;
        tick();
        covox_wr = 4'b0000;
        model_write(4'b1111, 1'b0, chg_data);
      end else begin
        tick();
      end
      check("pwm_dac", 32'(dac_pwm), (p <= duty) ? 32'd1 : 32'd0);
    end
    tick();
    check("pwm_stb_wrap", 32'(stb_pwm), 32'd1);
  endtask

  task automatic sdm_window(output int ones, output int repeats);
    logic prev;
    ones    = 0;
    repeats = 0;
    prev    = dac_sdm;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (dac_sdm === 1'b1) ones++;
      if (dac_sdm === prev) repeats++;
      prev = dac_sdm;
    end
  endtask

  initial begin
    int stb_hits;
    int ones;
    int repeats;

    for (int k = 0; k < 4; k++) m_chan[k] = 0;
    m_beep = 0;
    m_tape = 0;

    // Reset with every strobe active.
    rst_n     = 1'b0;
    covox_wr  = 4'b1111;
    beeper_wr = 1'b1;
    din       = 8'hFF;
    repeat (4) tick();
    check("rst_mix_pwm", 32'(mix_pwm), 32'd0);
    check("rst_mix_sdm", 32'(mix_sdm), 32'd0);
    check("rst_dac_pwm", 32'(dac_pwm), 32'd0);
    check("rst_dac_sdm", 32'(dac_sdm), 32'd0);
    check("rst_stb_pwm", 32'(stb_pwm), 32'd0);
    check("rst_stb_sdm", 32'(stb_sdm), 32'd0);

    covox_wr  = 4'b0000;
    beeper_wr = 1'b0;
    rst_n     = 1'b1;
    #1;
    check("rel_stb_pwm", 32'(stb_pwm), 32'd1);
    check("rel_stb_sdm", 32'(stb_sdm), 32'd1);
    stb_hits = 0;
    for (int i = 1; i < 256; i++) begin
      tick();
      if (stb_pwm === 1'b1 || stb_sdm === 1'b1) stb_hits++;
    end
    check("stb_quiet", 32'(stb_hits), 32'd0);
    tick();
    check("stb_period", 32'(stb_pwm), 32'd1);
    check("rst_cleared_mix", 32'(mix_pwm), 32'd0);

    // First channel write and full-scale saturation.
    xact(4'b0001, 1'b0, 8'h80);
    check("first_write", 32'(mix_pwm), 32'h20);
    xact(4'b1111, 1'b1, 8'hFF);
    check("sat_sum", 32'(dut_pwm.sum_reg), 32'h49C);
    check("sat_mix", 32'(mix_pwm), 32'hFF);

    // Random writes against the arithmetic model.
    for (int t = 0; t < 16; t++) begin
      xact(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    end

    // PWM duty 0x40, then a mid-period change to 0xC0.
    xact(4'b1111, 1'b1, 8'h00);
    xact(4'b0011, 1'b0, 8'h80);
    check("pwm_mix_40", 32'(mix_pwm), 32'h40);
    wait_stb();
    pwm_period(64, -1, 8'h00);
    pwm_period(64, 100, 8'hC0);
    pwm_period(192, -1, 8'h00);

    // Sigma-delta patterns.
    xact(4'b1111, 1'b1, 8'h80);
    repeat (3) tick();
    sdm_window(ones, repeats);
    check("sdm_80_ones", 32'(ones), 32'd128);
    check("sdm_80_toggle", 32'(repeats), 32'd0);
    xact(4'b1111, 1'b0, 8'h00);
    repeat (3) tick();
    sdm_window(ones, repeats);
    check("sdm_00_ones", 32'(ones), 32'd0);
    xact(4'b1111, 1'b0, 8'hFF);
    repeat (3) tick();
    sdm_window(ones, repeats);
    check("sdm_ff_ones", 32'(ones), 32'd255);

    // Reset in the middle of a 0xC0 PWM period.
    xact(4'b1111, 1'b0, 8'hC0);
    wait_stb();
    tick();
    wait_stb();
    repeat (50) tick();
    check("pre_rst_dac", 32'(dac_pwm), 32'd1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_dac_pwm", 32'(dac_pwm), 32'd0);
    check("mid_rst_dac_sdm", 32'(dac_sdm), 32'd0);
    check("mid_rst_mix", 32'(mix_pwm), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) m_chan[k] = 0;
    m_beep = 0;
    m_tape = 0;
    #1;
    check("mid_rel_stb", 32'(stb_pwm), 32'd1);
    repeat (3) tick();
    check("mid_rel_mix", 32'(mix_pwm), 32'(exp_mix()));
    ones     = 0;
    stb_hits = 0;
    for (int i = 0; i < 252; i++) begin
      tick();
      if (dac_pwm === 1'b1) ones++;
      if (stb_pwm === 1'b1) stb_hits++;
    end
    check("mid_rel_dac_ones", 32'(ones), 32'd0);
    check("mid_rel_stb_quiet", 32'(stb_hits), 32'd0);
    tick();
    check("mid_rel_stb_wrap", 32'(stb_pwm), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
